// File: rtl/dmem_boot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_boot_arbiter_pkg
// Purpose : Shared state encodings and default sizing for the boot arbiter.
// Rev     : 1.0
// ============================================================================
package dmem_boot_arbiter_pkg;

    localparam int C_DATA_W_DEF         = 32;
    localparam int C_MAX_WORDS_DEF      = 1024;
    localparam int C_CNT_W_DEF          = 16;
    localparam int C_RELEASE_CYCLES_DEF = 4;

    localparam int C_STATE_W = 2;

    localparam logic [C_STATE_W-1:0] ST_LOAD    = 2'd0;
    localparam logic [C_STATE_W-1:0] ST_RELEASE = 2'd1;
    localparam logic [C_STATE_W-1:0] ST_RUN     = 2'd2;
    localparam logic [C_STATE_W-1:0] ST_DBG     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dmem_boot_arbiter_timer.sv
`default_nettype none
// ============================================================================
// Module  : boot_release_timer
// Purpose : Loadable down-counter; o_done is high while the count is zero.
// Rev     : 1.0
// ============================================================================
module boot_release_timer #(
    parameter int CNT_W    = 16,
    parameter int LOAD_VAL = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(LOAD_VAL);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/dmem_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_boot_arbiter
// Purpose : Shares the data-memory port between the boot loader and the core.
// Rev     : 1.0
// ============================================================================
module dmem_boot_arbiter
    import dmem_boot_arbiter_pkg::*;
#(
    parameter int DATA_W         = C_DATA_W_DEF,
    parameter int MAX_WORDS      = C_MAX_WORDS_DEF,
    parameter int CNT_W          = C_CNT_W_DEF,
    parameter int RELEASE_CYCLES = C_RELEASE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic [DATA_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_done,
    output logic              ext_ready,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    input  logic              cpu_memwrite,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_reset,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  load_count
);

    logic [C_STATE_W-1:0] r_state;
    logic [C_STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]     r_load_count;
    logic                 r_cpu_stall;
    logic [DATA_W-1:0]    r_ext_rdata;
    logic                 r_ext_rvalid;

    logic w_wr_acc;
    logic w_load_last;
    logic w_capture;
    logic w_timer_load;
    logic w_timer_done;

    assign w_wr_acc    = (r_state == ST_LOAD) && ext_valid && ext_we;
    assign w_load_last = w_wr_acc && (r_load_count >= CNT_W'(MAX_WORDS - 1));
    // Read data is captured from the loader during LOAD or from the borrowed port in DBG.
    assign w_capture   = ((r_state == ST_LOAD) && ext_valid && !ext_we) || (r_state == ST_DBG);
    assign w_timer_load = (r_state == ST_LOAD) && (w_next_state == ST_RELEASE);

    boot_release_timer #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (RELEASE_CYCLES - 1)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_timer_load),
        .i_en   (r_state == ST_RELEASE),
        .o_done (w_timer_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (ext_done || w_load_last) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_timer_done) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Writes are never granted here; only reads borrow the port.
                if (ext_valid && !ext_we) begin
                    w_next_state = ST_DBG;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_comb begin
        cpu_reset = 1'b1;
        ext_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        case (r_state)
            ST_LOAD: begin
                ext_ready = 1'b1;
                mem_we    = ext_valid && ext_we;
            end
            ST_RELEASE: begin
                cpu_reset = 1'b1;
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                mem_we    = cpu_memwrite;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            default: begin
                cpu_reset = 1'b0;
                ext_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_count <= '0;
            r_cpu_stall  <= 1'b0;
            r_ext_rdata  <= '0;
            r_ext_rvalid <= 1'b0;
        end else begin
            if (w_wr_acc && (r_load_count < CNT_W'(MAX_WORDS))) begin
                r_load_count <= r_load_count + CNT_W'(1);
            end
            r_cpu_stall  <= (r_state == ST_RUN) && (w_next_state == ST_DBG);
            r_ext_rvalid <= w_capture;
            if (w_capture) begin
                r_ext_rdata <= mem_rdata;
            end
        end
    end

    assign state      = r_state;
    assign load_count = r_load_count;
    assign cpu_stall  = r_cpu_stall;
    assign ext_rdata  = r_ext_rdata;
    assign ext_rvalid = r_ext_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_boot_arbiter
// Purpose : Self-checking bench for dmem_boot_arbiter with a word-array memory model.
// Rev     : 1.0
// ============================================================================
module tb_dmem_boot_arbiter;

    localparam int         C_MAXW = 8;
    localparam int         C_RELC = 4;
    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_REL  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DBG  = 2'd3;

    logic        clk;
    logic        reset;
    logic        ext_valid;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_done;
    logic        ext_ready;
    logic [31:0] ext_rdata;
    logic        ext_rvalid;
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_reset;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  state;
    logic [15:0] load_count;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] dmem [0:255];
    logic [31:0] refm [0:255];

    dmem_boot_arbiter #(
        .DATA_W         (32),
        .MAX_WORDS      (C_MAXW),
        .CNT_W          (16),
        .RELEASE_CYCLES (C_RELC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_valid    (ext_valid),
        .ext_we       (ext_we),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_done     (ext_done),
        .ext_ready    (ext_ready),
        .ext_rdata    (ext_rdata),
        .ext_rvalid   (ext_rvalid),
        .cpu_memwrite (cpu_memwrite),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_reset    (cpu_reset),
        .cpu_stall    (cpu_stall),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .state        (state),
        .load_count   (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_addr[9:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ext_valid    = 1'b0;
        ext_we       = 1'b0;
        ext_addr     = '0;
        ext_wdata    = '0;
        ext_done     = 1'b0;
        cpu_memwrite = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d, input logic done);
        ext_valid = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = a;
        ext_wdata = d;
        ext_done  = done;
        #1;
        checks++;
        if (mem_we !== 1'b1 || ext_ready !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
            errors++;
            $display("FAIL load_write: we=%b rdy=%b addr=%h data=%h required we=1 rdy=1 addr=%h data=%h",
                     mem_we, ext_ready, mem_addr, mem_wdata, a, d);
        end
        refm[a[9:2]] = d;
        tick();
        ext_valid = 1'b0;
        ext_we    = 1'b0;
        ext_done  = 1'b0;
    endtask

    task automatic finish_load(input logic send_done);
        int n;
        logic bad;
        if (send_done) begin
            ext_done = 1'b1;
            #1;
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL done_cycle_we: mem_we=%b required 0", mem_we);
            end
            tick();
            ext_done = 1'b0;
        end
        n   = 0;
        bad = 1'b0;
        while (state === S_REL && n < 50) begin
            if (cpu_reset !== 1'b1 || ext_ready !== 1'b0 || mem_we !== 1'b0) bad = 1'b1;
            n++;
            tick();
        end
        checks++;
        if (bad || n != C_RELC || state !== S_RUN || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL release_dwell: cycles=%0d state=%0d cpu_reset=%b bad=%b required cycles=%0d state=2 cpu_reset=0",
                     n, state, cpu_reset, bad, C_RELC);
        end
    endtask

    task automatic dbg_read(input logic [31:0] a);
        logic [31:0] exp_d;
        exp_d     = refm[a[9:2]];
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = a;
        tick();
        // Core attempts a store during the stolen cycle; it must not land.
        cpu_memwrite = 1'b1;
        cpu_addr     = a;
        cpu_wdata    = ~exp_d;
        #1;
        checks++;
        if (state !== S_DBG || cpu_stall !== 1'b1 || ext_ready !== 1'b1 || mem_we !== 1'b0 ||
            mem_addr !== a || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL dbg_cycle: state=%0d stall=%b rdy=%b we=%b addr=%h required state=3 stall=1 rdy=1 we=0 addr=%h",
                     state, cpu_stall, ext_ready, mem_we, mem_addr, a);
        end
        tick();
        ext_valid    = 1'b0;
        cpu_memwrite = 1'b0;
        checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== exp_d || cpu_stall !== 1'b0 || state !== S_RUN) begin
            errors++;
            $display("FAIL dbg_data: rvalid=%b rdata=%h stall=%b state=%0d required rvalid=1 rdata=%h stall=0 state=2",
                     ext_rvalid, ext_rdata, cpu_stall, state, exp_d);
        end
        tick();
        checks++;
        if (ext_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse: rvalid=%b required 0", ext_rvalid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (state !== S_LOAD || load_count !== 16'd0 || cpu_reset !== 1'b1 || ext_rvalid !== 1'b0 ||
            cpu_stall !== 1'b0 || ext_rdata !== 32'd0 || ext_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%0d cpu_reset=%b rvalid=%b stall=%b rdata=%h rdy=%b required 0 0 1 0 0 0 1",
                     state, load_count, cpu_reset, ext_rvalid, cpu_stall, ext_rdata, ext_ready);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (state !== S_LOAD) begin
            errors++;
            $display("FAIL reset_release_state: state=%0d required 0", state);
        end
    endtask

    task automatic test_load_done();
        int base;
        logic [31:0] a;
        do_reset();
        base = we_cnt;
        for (int i = 0; i < 4; i++) begin
            ld_write(32'(i * 4), 32'hA0 + 32'(i), 1'b0);
        end
        // Loader read-back during LOAD
        a = 32'(4 * $urandom_range(0, 3));
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = a;
        #1;
        checks++;
        if (mem_we !== 1'b0 || ext_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_read_req: we=%b rdy=%b required we=0 rdy=1", mem_we, ext_ready);
        end
        tick();
        ext_valid = 1'b0;
        checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== refm[a[9:2]] || state !== S_LOAD) begin
            errors++;
            $display("FAIL load_read_data: rvalid=%b rdata=%h state=%0d required rvalid=1 rdata=%h state=0",
                     ext_rvalid, ext_rdata, state, refm[a[9:2]]);
        end
        finish_load(1'b1);
        checks++;
        if (we_cnt - base != 4 || load_count !== 16'd4) begin
            errors++;
            $display("FAIL load_counts: we_pulses=%0d load_count=%0d required 4 4", we_cnt - base, load_count);
        end
        for (int i = 3; i >= 0; i--) begin
            dbg_read(32'(i * 4));
        end
    endtask

    task automatic test_max_words();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < C_MAXW; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63) * 4);
            ld_write(a, $urandom, 1'b0);
            checks++;
            if (state !== ((i == C_MAXW - 1) ? S_REL : S_LOAD)) begin
                errors++;
                $display("FAIL max_words_state: write=%0d state=%0d required %0d",
                         i, state, (i == C_MAXW - 1) ? S_REL : S_LOAD);
            end
        end
        ext_valid = 1'b1;
        ext_we    = 1'b1;
        ext_addr  = 32'h100;
        ext_wdata = 32'hFFFF_0000;
        #1;
        checks++;
        if (ext_ready !== 1'b0 || mem_we !== 1'b0 || load_count !== 16'(C_MAXW)) begin
            errors++;
            $display("FAIL max_words_ninth: rdy=%b we=%b cnt=%0d required rdy=0 we=0 cnt=%0d",
                     ext_ready, mem_we, load_count, C_MAXW);
        end
        ext_valid = 1'b0;
        ext_we    = 1'b0;
        finish_load(1'b0);
    endtask

    task automatic test_done_coincident();
        do_reset();
        ld_write(32'h300, $urandom, 1'b0);
        ld_write(32'h304, $urandom, 1'b0);
        ld_write(32'h20, 32'hDEADBEEF, 1'b1);
        checks++;
        if (state !== S_REL || load_count !== 16'd3) begin
            errors++;
            $display("FAIL coincident_done: state=%0d cnt=%0d required state=1 cnt=3", state, load_count);
        end
        finish_load(1'b0);
        ext_done = 1'b1;
        repeat (3) tick();
        ext_done = 1'b0;
        checks++;
        if (state !== S_RUN || load_count !== 16'd3 || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL done_ignored_in_run: state=%0d cnt=%0d cpu_reset=%b required 2 3 0",
                     state, load_count, cpu_reset);
        end
        dbg_read(32'h20);
        dbg_read(32'h304);
    endtask

    task automatic test_store_collision();
        cpu_memwrite = 1'b1;
        cpu_addr     = 32'h44;
        cpu_wdata    = 32'h1234_5678;
        refm[32'h44 >> 2] = 32'h1234_5678;
        tick();
        cpu_addr     = 32'h40;
        cpu_wdata    = 32'h55;
        ext_valid    = 1'b1;
        ext_we       = 1'b0;
        ext_addr     = 32'h40;
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h55 || ext_ready !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL collide_store: we=%b addr=%h data=%h rdy=%b stall=%b required 1 40 55 0 0",
                     mem_we, mem_addr, mem_wdata, ext_ready, cpu_stall);
        end
        refm[32'h40 >> 2] = 32'h55;
        tick();
        cpu_addr  = 32'h44;
        cpu_wdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (state !== S_DBG || cpu_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL collide_dbg: state=%0d stall=%b we=%b addr=%h required 3 1 0 40",
                     state, cpu_stall, mem_we, mem_addr);
        end
        tick();
        ext_valid    = 1'b0;
        cpu_memwrite = 1'b0;
        checks++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h55) begin
            errors++;
            $display("FAIL collide_rdata: rvalid=%b rdata=%h required 1 00000055", ext_rvalid, ext_rdata);
        end
        dbg_read(32'h44);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[$];
        logic [31:0] a;
        logic [31:0] pend;
        logic        prev_stall;
        logic        exp_stall;
        for (int i = 0; i < 6; i++) begin
            a = 32'h180 + 32'($urandom_range(0, 31) * 4);
            cpu_memwrite = 1'b1;
            cpu_addr     = a;
            cpu_wdata    = $urandom;
            refm[a[9:2]] = cpu_wdata;
            addrs.push_back(a);
            #1;
            checks++;
            if (mem_we !== 1'b1 || cpu_stall !== 1'b0 || cpu_reset !== 1'b0) begin
                errors++;
                $display("FAIL core_store: we=%b stall=%b cpu_reset=%b required 1 0 0", mem_we, cpu_stall, cpu_reset);
            end
            tick();
        end
        cpu_memwrite = 1'b0;
        a          = addrs[$urandom_range(0, 5)];
        pend       = a;
        ext_valid  = 1'b1;
        ext_we     = 1'b0;
        ext_addr   = a;
        prev_stall = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_stall = (i % 2 == 1);
            checks++;
            if (cpu_stall !== exp_stall || (prev_stall && cpu_stall)) begin
                errors++;
                $display("FAIL b2b_stall: cycle=%0d stall=%b prev=%b required %b", i, cpu_stall, prev_stall, exp_stall);
            end
            prev_stall = cpu_stall;
            if (exp_stall) begin
                pend = a;
            end else begin
                checks++;
                if (ext_rvalid !== 1'b1 || ext_rdata !== refm[pend[9:2]]) begin
                    errors++;
                    $display("FAIL b2b_rdata: cycle=%0d rvalid=%b rdata=%h required 1 %h",
                             i, ext_rvalid, ext_rdata, refm[pend[9:2]]);
                end
                a        = addrs[$urandom_range(0, 5)];
                ext_addr = a;
            end
        end
        ext_valid = 1'b0;
        tick();
        checks++;
        if (state !== S_RUN || ext_rvalid !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: state=%0d rvalid=%b stall=%b required 2 0 0", state, ext_rvalid, cpu_stall);
        end
    endtask

    task automatic test_reset_in_dbg();
        ext_valid = 1'b1;
        ext_we    = 1'b0;
        ext_addr  = 32'h20;
        tick();
        checks++;
        if (state !== S_DBG || load_count === 16'd0) begin
            errors++;
            $display("FAIL pre_reset_dbg: state=%0d cnt=%0d required state=3 cnt!=0", state, load_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || state !== S_LOAD || ext_rvalid !== 1'b0 || load_count !== 16'd0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cpu_reset=%b state=%0d rvalid=%b cnt=%0d stall=%b required 1 0 0 0 0",
                     cpu_reset, state, ext_rvalid, load_count, cpu_stall);
        end
        ext_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if (ext_rvalid !== 1'b0 || state !== S_LOAD || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: rvalid=%b state=%0d cpu_reset=%b required 0 0 1", ext_rvalid, state, cpu_reset);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refm[i] = '0;
        reset = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_load_done();
        test_max_words();
        test_done_coincident();
        test_store_collision();
        test_back_to_back();
        test_reset_in_dbg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
